// File: rtl/serial_pkg.sv
// Shared definitions for the serial scheduler, master/slave models and benches.
// Contents: scheduler FSM state encoding, last_status result codes, and a
// counter-width helper used to size the retry/backoff/timeout counters.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SELECT,
    S_WAIT,
    S_BACKOFF,
    S_NEXT,
    S_FINISH
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE      = 3'd0,
    ST_OK        = 3'd1,
    ST_FAIL      = 3'd2,
    ST_CHECKERR  = 3'd3,
    ST_NOANSWER  = 3'd4,
    ST_TIMEOUT   = 3'd5
  } status_t;

  // Bits needed to hold 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_scheduler_if.sv
// Handshake bundle between the scheduler and the serial master / slave select.
// master modport: scheduler side (drives mem_addr, MCS, SCS; receives ready
//                 and the one-cycle result pulses ok/fail/checkerr/noAnswer).
// slave modport : responder side (the serial master and its result pulses).
interface serial_scheduler_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] mem_addr;
  logic              MCS;
  logic              SCS;
  logic              ready;
  logic              ok;
  logic              fail;
  logic              checkerr;
  logic              noAnswer;

  modport master (
    output mem_addr, MCS, SCS,
    input  ready, ok, fail, checkerr, noAnswer
  );

  modport slave (
    input  mem_addr, MCS, SCS,
    output ready, ok, fail, checkerr, noAnswer
  );
endinterface

// File: rtl/serial_retry_timer.sv
// Retry, backoff and timeout counting for the serial scheduler.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   wait_en       : scheduler is in WAIT; counts WAIT cycles
//   backoff_en    : scheduler is in BACKOFF; counts idle cycles
//   retry_clr     : clear retry counter (batch start, ok, word dropped)
//   retry_inc     : count one more retry for the current word
//   timeout       : current WAIT cycle is the TIMEOUT-th one
//   backoff_done  : current BACKOFF cycle is the BACKOFF-th one
//   retry_left    : retries used so far are below MAX_RETRY
module serial_retry_timer
  import serial_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_en,
  input  logic backoff_en,
  input  logic retry_clr,
  input  logic retry_inc,
  output logic timeout,
  output logic backoff_done,
  output logic retry_left
);

  localparam int unsigned RW = cnt_width(MAX_RETRY);
  localparam int unsigned BW = cnt_width(BACKOFF);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  logic [RW-1:0] retry_cnt;
  logic [BW-1:0] backoff_cnt;
  logic [TW-1:0] wait_cnt;

  // Cycle counters restart from zero whenever their state is left, so each
  // WAIT / BACKOFF visit is measured from its own first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cnt   <= '0;
      backoff_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      wait_cnt    <= wait_en    ? wait_cnt + TW'(1)    : '0;
      backoff_cnt <= backoff_en ? backoff_cnt + BW'(1) : '0;
      if (retry_clr)
        retry_cnt <= '0;
      else if (retry_inc)
        retry_cnt <= retry_cnt + RW'(1);
    end
  end

  assign timeout      = wait_en && (wait_cnt == TW'(TIMEOUT - 1));
  assign backoff_done = backoff_en && (backoff_cnt == BW'(BACKOFF - 1));
  assign retry_left   = (retry_cnt < RW'(MAX_RETRY));

endmodule

// File: rtl/serial_scheduler.sv
// Batch transfer scheduler: walks memory words first_addr..last_addr (wrapping
// modulo 2^ADDR_W), drives the serial master and slave selects for each word,
// retries failed words after a backoff and abandons them after MAX_RETRY.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : level, sampled only in IDLE (with bus.ready)
//   first_addr, last_addr : inclusive batch bounds
//   bus (master)          : mem_addr/MCS/SCS out, ready + result pulses in
//   busy                  : high outside IDLE
//   done                  : one-cycle pulse at batch end
//   sent_cnt, drop_cnt    : words acknowledged ok / abandoned
//   last_status           : 0 none, 1 ok, 2 fail, 3 checkerr, 4 noAnswer, 5 timeout
module serial_scheduler
  import serial_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  serial_scheduler_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sent_cnt,
  output logic [ADDR_W:0]     drop_cnt,
  output logic [2:0]          last_status
);

  localparam int unsigned CW = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              mcs;
  logic              scs;
  logic              launch;
  logic              result_hit;
  status_t           result_code;
  logic              timeout;
  logic              backoff_done;
  logic              retry_left;
  logic              retry_clr;
  logic              retry_inc;

  assign bus.mem_addr = mem_addr;
  assign bus.MCS      = mcs;
  assign bus.SCS      = scs;

  assign launch = (state == S_IDLE) && start && bus.ready;

  // Result decode, only meaningful in WAIT. Priority ok > checkerr > fail >
  // noAnswer; a real pulse on the last WAIT cycle wins over the timeout.
  always_comb begin
    result_hit  = 1'b0;
    result_code = ST_NONE;
    if (state == S_WAIT) begin
      result_hit = 1'b1;
      if (bus.ok)            result_code = ST_OK;
      else if (bus.checkerr) result_code = ST_CHECKERR;
      else if (bus.fail)     result_code = ST_FAIL;
      else if (bus.noAnswer) result_code = ST_NOANSWER;
      else if (timeout)      result_code = ST_TIMEOUT;
      else                   result_hit  = 1'b0;
    end
  end

  assign retry_clr = launch || (result_hit && ((result_code == ST_OK) || !retry_left));
  assign retry_inc = result_hit && (result_code != ST_OK) && retry_left;

  serial_retry_timer #(
    .MAX_RETRY (MAX_RETRY),
    .BACKOFF   (BACKOFF),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .wait_en      (state == S_WAIT),
    .backoff_en   (state == S_BACKOFF),
    .retry_clr    (retry_clr),
    .retry_inc    (retry_inc),
    .timeout      (timeout),
    .backoff_done (backoff_done),
    .retry_left   (retry_left)
  );

  // Selects are registered and set on the transition into ISSUE/SELECT, so
  // MCS leads SCS by exactly one cycle and both drop the cycle after a result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_addr    <= '0;
      end_addr    <= '0;
      mcs         <= 1'b0;
      scs         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sent_cnt    <= '0;
      drop_cnt    <= '0;
      last_status <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            mem_addr    <= first_addr;
            // Batch end is captured here so it cannot move mid-batch.
            end_addr    <= last_addr;
            sent_cnt    <= '0;
            drop_cnt    <= '0;
            last_status <= ST_NONE;
            busy        <= 1'b1;
            mcs         <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          scs   <= 1'b1;
          state <= S_SELECT;
        end
        S_SELECT: state <= S_WAIT;
        S_WAIT: begin
          if (result_hit) begin
            mcs         <= 1'b0;
            scs         <= 1'b0;
            last_status <= result_code;
            if (result_code == ST_OK) begin
              sent_cnt <= sent_cnt + CW'(1);
              state    <= S_NEXT;
            end else if (retry_left) begin
              state <= S_BACKOFF;
            end else begin
              drop_cnt <= drop_cnt + CW'(1);
              state    <= S_NEXT;
            end
          end
        end
        S_BACKOFF: begin
          if (backoff_done) begin
            mcs   <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_NEXT: begin
          if (mem_addr == end_addr) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            mcs      <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_scheduler.sv
// Self-checking bench for serial_scheduler. The bench plays the serial master:
// it answers each transfer with a chosen result (random, fixed or scripted),
// injects stray pulses where they must be ignored, and predicts addresses,
// counters, status and backoff gaps from the word-level retry rules.
module tb_serial_scheduler;

  localparam int ADDR_W    = 4;
  localparam int MAX_RETRY = 3;
  localparam int BACKOFF   = 8;
  localparam int TIMEOUT   = 1023;
  localparam int BUDGET    = 20000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sent_cnt;
  logic [ADDR_W:0]   drop_cnt;
  logic [2:0]        last_status;

  int checks = 0;
  int errors = 0;
  int plan[$];

  serial_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  serial_scheduler #(
    .ADDR_W    (ADDR_W),
    .MAX_RETRY (MAX_RETRY),
    .BACKOFF   (BACKOFF),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_addr  (first_addr),
    .last_addr   (last_addr),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .sent_cnt    (sent_cnt),
    .drop_cnt    (drop_cnt),
    .last_status (last_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Response encoding: bit0 ok, bit1 fail, bit2 checkerr, bit3 noAnswer,
  // 0 = stay silent (timeout).
  function automatic int status_of(input int r);
    if (r & 1) return 1;
    if (r & 4) return 3;
    if (r & 2) return 2;
    if (r & 8) return 4;
    return 5;
  endfunction

  function automatic int pick(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return 8;
    return ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(1, 15));
  endfunction

  task automatic drive(input logic [3:0] v);
    bus.ok       = v[0];
    bus.fail     = v[1];
    bus.checkerr = v[2];
    bus.noAnswer = v[3];
  endtask

  // Runs one batch. mode: 0 random, 1 all ok, 2 all noAnswer; scripted
  // responses in plan[] take precedence. abort_xfer>0 asserts reset in the
  // WAIT phase of that transfer and returns after checking the reset state.
  task automatic run_batch(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int mode, input int abort_xfer, output int xfers);
    int k, delay, resp, gap, exp_gap, fails, exp_sent, exp_drop, code, done_seen, cyc;
    logic [ADDR_W-1:0] exp_addr;
    logic [3:0] drv;
    logic prev_mcs, finished, ended;
    @(negedge clk);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    bus.ready  = 1'b1;
    exp_addr = f; exp_sent = 0; exp_drop = 0; fails = 0; xfers = 0;
    k = 0; delay = 0; resp = 0; gap = 0; exp_gap = -1; done_seen = 0;
    prev_mcs = 1'b0; finished = 1'b0; ended = 1'b0;
    for (cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge clk);
      if (cyc == 3) start = 1'b0;
      drv = '0;
      if (done) begin
        done_seen++;
        check("done_timing", finished, 1);
      end
      if (bus.MCS && !prev_mcs) begin
        xfers++;
        check("xfer_addr", bus.mem_addr, exp_addr);
        if (finished) check("extra_xfer", 1, 0);
        if (exp_gap >= 0) check("backoff_gap", gap, exp_gap);
        check("scs_lead", bus.SCS, 0);
        k = 0;
        resp  = (plan.size() > 0) ? plan.pop_front() : pick(mode);
        delay = $urandom_range(0, 4);
        if (xfers == abort_xfer) resp = 0;
      end else if (bus.MCS) begin
        k++;
        if (k == 1) check("scs_follow", bus.SCS, 1);
      end
      if (bus.MCS) begin
        if (xfers == abort_xfer && k == 4) begin
          reset = 1'b1;
          drive('0);
          #1;
          check("rst_mcs", bus.MCS, 0);
          check("rst_scs", bus.SCS, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_addr", bus.mem_addr, 0);
          check("rst_sent", sent_cnt, 0);
          check("rst_drop", drop_cnt, 0);
          check("rst_status", last_status, 0);
          return;
        end
        if (k < 2 && $urandom_range(0, 2) == 0) drv = 4'($urandom_range(1, 15));
        if (resp != 0 && k == 2 + delay) drv = 4'(resp);
      end else if (prev_mcs) begin
        check("mcs_len", k + 1, (resp != 0) ? 3 + delay : 2 + TIMEOUT);
        check("scs_drop", bus.SCS, 0);
        code = status_of(resp);
        if (code == 1) begin
          exp_sent++;
          fails = 0;
          exp_gap = -1;
        end else if (fails < MAX_RETRY) begin
          fails++;
          exp_gap = BACKOFF;
        end else begin
          exp_drop++;
          fails = 0;
          exp_gap = -1;
        end
        if (exp_gap < 0) begin
          if (exp_addr == l) finished = 1'b1;
          else exp_addr = exp_addr + 1'b1;
        end
        check("status", last_status, code);
        check("sent", sent_cnt, exp_sent);
        check("drop", drop_cnt, exp_drop);
        gap = 1;
      end else if (busy) begin
        gap++;
        if ($urandom_range(0, 3) == 0) drv = 4'($urandom_range(1, 15));
      end
      drive(drv);
      prev_mcs = bus.MCS;
      if (finished && !busy) begin
        ended = 1'b1;
        break;
      end
    end
    drive('0);
    check("batch_end", ended, 1);
    check("done_count", done_seen, 1);
  endtask

  initial begin
    int x;
    logic [ADDR_W-1:0] f, l;
    reset = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
    bus.ready = 1'b1;
    drive('0);
    repeat (3) @(negedge clk);
    check("init_mcs", bus.MCS, 0);
    check("init_scs", bus.SCS, 0);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_addr", bus.mem_addr, 0);
    check("init_sent", sent_cnt, 0);
    check("init_drop", drop_cnt, 0);
    check("init_status", last_status, 0);
    reset = 1'b0;

    // start without ready must not launch
    start = 1'b1; bus.ready = 1'b0; first_addr = 4'd3; last_addr = 4'd3;
    repeat (4) @(negedge clk);
    check("noready_busy", busy, 0);
    check("noready_mcs", bus.MCS, 0);
    start = 1'b0; bus.ready = 1'b1;

    run_batch(4'd1, 4'd3, 1, 0, x);
    check("ok3_xfers", x, 3);
    check("ok3_sent", sent_cnt, 3);
    check("ok3_drop", drop_cnt, 0);

    run_batch(4'd5, 4'd5, 2, 0, x);
    check("noans_xfers", x, MAX_RETRY + 1);
    check("noans_drop", drop_cnt, 1);
    check("noans_status", last_status, 4);

    plan = '{1, 4, 1, 1};
    run_batch(4'd1, 4'd3, 1, 0, x);
    check("chk_xfers", x, 4);
    check("chk_sent", sent_cnt, 3);
    check("chk_status", last_status, 1);

    plan = '{0, 1};
    run_batch(4'd7, 4'd7, 1, 0, x);
    check("tmo_xfers", x, 2);
    check("tmo_sent", sent_cnt, 1);

    run_batch(4'd14, 4'd1, 1, 0, x);
    check("wrap_xfers", x, 4);
    check("wrap_sent", sent_cnt, 4);

    // values hold in IDLE while ready/pulses wiggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.ready = 1'($urandom_range(0, 1));
      drive(4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    drive('0); bus.ready = 1'b1;
    check("hold_sent", sent_cnt, 4);
    check("hold_drop", drop_cnt, 0);
    check("hold_status", last_status, 1);
    check("hold_busy", busy, 0);

    run_batch(4'd2, 4'd6, 1, 3, x);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_mcs", bus.MCS, 0);
    run_batch(4'd2, 4'd6, 1, 0, x);
    check("restart_xfers", x, 5);
    check("restart_sent", sent_cnt, 5);

    for (int n = 0; n < 8; n++) begin
      f = 4'($urandom_range(0, 15));
      l = f + 4'($urandom_range(0, 3));
      run_batch(f, l, 0, 0, x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
